// File: rtl/conv_column_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_column_feeder_if: pixel-in / column-out bundle for the column feeder  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface conv_column_feeder_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    frame_start;
  logic [DATA_WIDTH-1:0]   pix_in;
  logic                    pix_valid;
  logic                    pix_ready;
  logic [3*DATA_WIDTH-1:0] col_out;
  logic                    col_valid;
  logic                    col_last;
  logic                    frame_done;

  modport master (
    output frame_start, pix_in, pix_valid,
    input  pix_ready, col_out, col_valid, col_last, frame_done
  );

  modport slave (
    input  frame_start, pix_in, pix_valid,
    output pix_ready, col_out, col_valid, col_last, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/conv_column_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv_column_feeder: two-row line buffer turning a raster pixel stream into |
// | packed 3-row columns. CONV_FEEDER_ZERO_PAD_EN adds top zero padding.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module conv_column_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  wire logic            clk,
  input  wire logic            rst,
  conv_column_feeder_if.slave  bus
);
  localparam int X_W = $clog2(IMG_WIDTH);
  localparam int Y_W = $clog2(IMG_HEIGHT);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [X_W-1:0]          x_q, x_d;
  logic [Y_W-1:0]          y_q, y_d;
  logic [3*DATA_WIDTH-1:0] col_out_q, col_out_d;
  logic                    col_valid_q, col_valid_d;
  logic                    col_last_q, col_last_d;
  logic                    frame_done_q, frame_done_d;

  logic [DATA_WIDTH-1:0]   lb0_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0]   lb1_q [IMG_WIDTH];

  logic                    pix_ready;
  logic                    accept;
  logic                    x_last;
  logic [DATA_WIDTH-1:0]   row_top;
  logic [DATA_WIDTH-1:0]   row_mid;

  assign pix_ready = (state_q == S_FILL) || (state_q == S_STREAM);
  // frame_start wins over a pixel offered in the same cycle
  assign accept    = bus.pix_valid && pix_ready && !bus.frame_start;
  assign x_last    = (x_q == X_LAST);

  always_comb begin
    row_top = lb1_q[x_q];
    row_mid = lb0_q[x_q];
`ifdef CONV_FEEDER_ZERO_PAD_EN
    if (state_q == S_FILL) begin
      row_top = '0;
      if (y_q == '0) row_mid = '0;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    col_out_d    = col_out_q;
    col_valid_d  = 1'b0;
    col_last_d   = 1'b0;
    frame_done_d = (state_q == S_DONE);

    if (bus.frame_start) begin
      state_d = S_FILL;
      x_d     = '0;
      y_d     = '0;
    end else if (accept) begin
      col_out_d = {row_top, row_mid, bus.pix_in};
`ifdef CONV_FEEDER_ZERO_PAD_EN
      col_valid_d = 1'b1;
`else
      col_valid_d = (state_q == S_STREAM);
`endif
      col_last_d = col_valid_d && x_last;
      if (x_last) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          state_d = S_DONE;
        end else begin
          y_d = y_q + 1'b1;
          if (y_q == Y_W'(1)) state_d = S_STREAM;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      col_out_q    <= '0;
      col_valid_q  <= 1'b0;
      col_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      col_out_q    <= col_out_d;
      col_valid_q  <= col_valid_d;
      col_last_q   <= col_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers carry no reset; FILL rewrites both rows before they are read
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[x_q] <= lb0_q[x_q];
      lb0_q[x_q] <= bus.pix_in;
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.col_out    = col_out_q;
  assign bus.col_valid  = col_valid_q;
  assign bus.col_last   = col_last_q;
  assign bus.frame_done = frame_done_q;
endmodule
`default_nettype wire
